// File: rtl/store_commit_buffer.sv
// store_commit_buffer: FIFO of retired stores feeding the L1D write port in program order,
// with miss retry, stall back-pressure and load/store doubleword overlap detection.
// Optional macro STB_PERF_CNT_EN adds enqueue / retry / full-stall performance counters.
module store_commit_buffer #(
    parameter int DEPTH       = 8,
    parameter int RETRY_DELAY = 4,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stCommitValid_i,
    input  logic [ADDR_W-1:0]       stCommitAddr_i,
    input  logic [DATA_W-1:0]       stCommitData_i,
    input  logic [1:0]              stCommitSize_i,
    output logic                    stCommitReady_o,
    output logic                    wrEn_o,
    output logic [ADDR_W-1:0]       wrAddr_o,
    output logic [DATA_W-1:0]       wrData_o,
    output logic [1:0]              stSize_o,
    input  logic                    wrHit_i,
    input  logic                    stallStCommit_i,
    input  logic [ADDR_W-1:0]       ldCheckAddr_i,
    input  logic                    ldCheckValid_i,
    output logic                    ldConflict_o,
    input  logic                    drainReq_i,
    output logic                    drained_o,
`ifdef STB_PERF_CNT_EN
    output logic [31:0]             perfEnq_o,
    output logic [31:0]             perfRetry_o,
    output logic [31:0]             perfFullStall_o,
`endif
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
    localparam logic [ADDR_W-1:0] DW_MASK = ~ADDR_W'(3'd7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RETRY = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     retry_q, retry_d;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [1:0]        size_mem [DEPTH];

    logic              push_s;
    logic              pop_s;
    logic              wr_en_s;
    logic              ready_s;
    logic              conflict_s;
    logic [DEPTH-1:0]  valid_s;
    logic [PW-1:0]     offs_s;

    // Acceptance looks only at registered occupancy, so a full buffer rejects even while popping.
    always_comb begin
        ready_s = (count_q < CW'(DEPTH)) && !drainReq_i;
        push_s  = stCommitValid_i && ready_s;
    end

    // Drain FSM: issue head, retry after a miss, hold under cache stall.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        wr_en_s = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (push_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wr_en_s = !stallStCommit_i;
                if (wr_en_s && wrHit_i) begin
                    pop_s = 1'b1;
                    if ((count_q == CW'(1)) && !push_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (wr_en_s) begin
                    state_d = ST_RETRY;
                    retry_d = RW'(RETRY_DELAY - 1);
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RETRY: begin
                if (retry_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    retry_d = retry_q - RW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer and occupancy update; power-of-two depth makes pointer wrap implicit.
    always_comb begin
        head_d  = pop_s  ? head_q + PW'(1) : head_q;
        tail_d  = push_s ? tail_q + PW'(1) : tail_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            retry_q <= retry_d;
        end
    end

    // Entry storage is deliberately not reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem[tail_q] <= stCommitAddr_i;
            data_mem[tail_q] <= stCommitData_i;
            size_mem[tail_q] <= stCommitSize_i;
        end
    end

    // Doubleword overlap check against every occupied slot, including a head waiting in RETRY.
    always_comb begin
        valid_s    = '0;
        offs_s     = '0;
        conflict_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offs_s     = PW'(i) - head_q;
            valid_s[i] = ({1'b0, offs_s} < count_q);
            conflict_s = conflict_s |
                         (valid_s[i] && (((addr_mem[i] ^ ldCheckAddr_i) & DW_MASK) == '0));
        end
    end

    assign stCommitReady_o = ready_s;
    assign wrEn_o          = wr_en_s;
    assign wrAddr_o        = addr_mem[head_q];
    assign wrData_o        = data_mem[head_q];
    assign stSize_o        = size_mem[head_q];
    assign ldConflict_o    = ldCheckValid_i && conflict_s;
    assign drained_o       = (count_q == '0) && (state_q == ST_IDLE);
    assign count_o         = count_q;

`ifdef STB_PERF_CNT_EN
    logic [31:0] perf_enq_q, perf_enq_d;
    logic [31:0] perf_retry_q, perf_retry_d;
    logic [31:0] perf_full_q, perf_full_d;

    // Wrapping event counters.
    always_comb begin
        perf_enq_d   = perf_enq_q   + {31'd0, push_s};
        perf_retry_d = perf_retry_q + {31'd0, (state_q == ST_ISSUE) && (state_d == ST_RETRY)};
        perf_full_d  = perf_full_q  + {31'd0, stCommitValid_i && !ready_s};
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_enq_q   <= 32'd0;
            perf_retry_q <= 32'd0;
            perf_full_q  <= 32'd0;
        end else begin
            perf_enq_q   <= perf_enq_d;
            perf_retry_q <= perf_retry_d;
            perf_full_q  <= perf_full_d;
        end
    end

    assign perfEnq_o       = perf_enq_q;
    assign perfRetry_o     = perf_retry_q;
    assign perfFullStall_o = perf_full_q;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer (default build, DEPTH=8, RETRY_DELAY=4).
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stCommitValid_i;
    logic [63:0] stCommitAddr_i;
    logic [63:0] stCommitData_i;
    logic [1:0]  stCommitSize_i;
    logic        stCommitReady_o;
    logic        wrEn_o;
    logic [63:0] wrAddr_o;
    logic [63:0] wrData_o;
    logic [1:0]  stSize_o;
    logic        wrHit_i;
    logic        stallStCommit_i;
    logic [63:0] ldCheckAddr_i;
    logic        ldCheckValid_i;
    logic        ldConflict_o;
    logic        drainReq_i;
    logic        drained_o;
    logic [3:0]  count_o;

    int errors = 0;
    int checks = 0;

    store_commit_buffer dut (
        .clk(clk), .reset(reset),
        .stCommitValid_i(stCommitValid_i), .stCommitAddr_i(stCommitAddr_i),
        .stCommitData_i(stCommitData_i), .stCommitSize_i(stCommitSize_i),
        .stCommitReady_o(stCommitReady_o),
        .wrEn_o(wrEn_o), .wrAddr_o(wrAddr_o), .wrData_o(wrData_o), .stSize_o(stSize_o),
        .wrHit_i(wrHit_i), .stallStCommit_i(stallStCommit_i),
        .ldCheckAddr_i(ldCheckAddr_i), .ldCheckValid_i(ldCheckValid_i),
        .ldConflict_o(ldConflict_o),
        .drainReq_i(drainReq_i), .drained_o(drained_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic v, input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        stCommitValid_i = v;
        stCommitAddr_i  = a;
        stCommitSize_i  = s;
        stCommitData_i  = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        offer(1'b0, 64'd0, 2'd0, 64'd0);
        wrHit_i = 1'b1; stallStCommit_i = 1'b0; drainReq_i = 1'b0;
        ldCheckValid_i = 1'b1; ldCheckAddr_i = 64'd0;
        #3;
        checks++; if (stCommitReady_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", stCommitReady_o); end
        checks++; if (wrEn_o !== 1'b0) begin errors++; $display("FAIL rst_wren: got %0b expected 0", wrEn_o); end
        checks++; if (ldConflict_o !== 1'b0) begin errors++; $display("FAIL rst_conflict: got %0b expected 0", ldConflict_o); end
        checks++; if (drained_o !== 1'b1) begin errors++; $display("FAIL rst_drained: got %0b expected 1", drained_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count_o); end
        ldCheckValid_i = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] a_t [3];
        logic [63:0] d_t [3];
        logic [1:0]  s_t [3];
        a_t[0] = 64'h1000; s_t[0] = 2'd3; d_t[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        a_t[1] = 64'h1008; s_t[1] = 2'd0; d_t[1] = 64'h55;
        a_t[2] = 64'h2004; s_t[2] = 2'd2; d_t[2] = 64'h1234_5678;
        wrHit_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) offer(1'b1, a_t[i], s_t[i], d_t[i]);
            else       offer(1'b0, 64'd0, 2'd0, 64'd0);
            #1;
            if (i == 0) begin
                checks++; if (wrEn_o !== 1'b0) begin errors++; $display("FAIL basic_nobypass: got %0b expected 0", wrEn_o); end
            end else begin
                checks++; if (wrEn_o !== 1'b1) begin errors++; $display("FAIL basic_wren[%0d]: got %0b expected 1", i, wrEn_o); end
                checks++; if (wrAddr_o !== a_t[i-1]) begin errors++; $display("FAIL basic_addr[%0d]: got %0h expected %0h", i, wrAddr_o, a_t[i-1]); end
                checks++; if (wrData_o !== d_t[i-1]) begin errors++; $display("FAIL basic_data[%0d]: got %0h expected %0h", i, wrData_o, d_t[i-1]); end
                checks++; if (stSize_o !== s_t[i-1]) begin errors++; $display("FAIL basic_size[%0d]: got %0d expected %0d", i, stSize_o, s_t[i-1]); end
                checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL basic_count[%0d]: got %0d expected 1", i, count_o); end
            end
            tick();
        end
        #1;
        checks++; if (drained_o !== 1'b1) begin errors++; $display("FAIL basic_drained: got %0b expected 1", drained_o); end
        checks++; if (wrEn_o !== 1'b0) begin errors++; $display("FAIL basic_idle_wren: got %0b expected 0", wrEn_o); end
    endtask

    task automatic test_full();
        stallStCommit_i = 1'b1; wrHit_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            offer(1'b1, 64'h4000 + 64'(8 * k), 2'd3, 64'(k + 100));
            #1;
            checks++; if (stCommitReady_o !== 1'b1) begin errors++; $display("FAIL full_ready_fill[%0d]: got %0b expected 1", k, stCommitReady_o); end
            tick();
        end
        offer(1'b1, 64'h5000, 2'd3, 64'hDEAD);
        #1;
        checks++; if (stCommitReady_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", stCommitReady_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count_o); end
        checks++; if (wrEn_o !== 1'b0) begin errors++; $display("FAIL full_stall_wren: got %0b expected 0", wrEn_o); end
        tick();
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_9th_rejected: got %0d expected 8", count_o); end
        offer(1'b0, 64'd0, 2'd0, 64'd0);
        stallStCommit_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (wrEn_o !== 1'b1) begin errors++; $display("FAIL full_pop_wren[%0d]: got %0b expected 1", k, wrEn_o); end
            checks++; if (wrAddr_o !== 64'h4000 + 64'(8 * k)) begin errors++; $display("FAIL full_pop_addr[%0d]: got %0h expected %0h", k, wrAddr_o, 64'h4000 + 64'(8 * k)); end
            checks++; if (count_o !== 4'(8 - k)) begin errors++; $display("FAIL full_pop_count[%0d]: got %0d expected %0d", k, count_o, 8 - k); end
            checks++; if (stCommitReady_o !== (k > 0)) begin errors++; $display("FAIL full_pop_ready[%0d]: got %0b expected %0b", k, stCommitReady_o, k > 0); end
            tick();
        end
        #1;
        checks++; if (drained_o !== 1'b1) begin errors++; $display("FAIL full_drained: got %0b expected 1", drained_o); end
    endtask

    task automatic test_retry();
        wrHit_i = 1'b0;
        offer(1'b1, 64'h6000, 2'd3, 64'h77);
        tick();
        offer(1'b0, 64'd0, 2'd0, 64'd0);
        #1;
        checks++; if (wrEn_o !== 1'b1 || wrAddr_o !== 64'h6000) begin errors++; $display("FAIL retry_first_issue: got en=%0b addr=%0h expected en=1 addr=6000", wrEn_o, wrAddr_o); end
        tick();
        for (int c = 0; c < 4; c++) begin
            ldCheckValid_i = 1'b1; ldCheckAddr_i = 64'h6004;
            #1;
            checks++; if (wrEn_o !== 1'b0) begin errors++; $display("FAIL retry_wait_wren[%0d]: got %0b expected 0", c, wrEn_o); end
            checks++; if (ldConflict_o !== 1'b1) begin errors++; $display("FAIL retry_conflict[%0d]: got %0b expected 1", c, ldConflict_o); end
            checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL retry_count[%0d]: got %0d expected 1", c, count_o); end
            tick();
        end
        ldCheckValid_i = 1'b0;
        wrHit_i = 1'b1;
        #1;
        checks++; if (wrEn_o !== 1'b1 || wrAddr_o !== 64'h6000) begin errors++; $display("FAIL retry_reissue: got en=%0b addr=%0h expected en=1 addr=6000", wrEn_o, wrAddr_o); end
        tick();
        #1;
        checks++; if (count_o !== 4'd0 || drained_o !== 1'b1) begin errors++; $display("FAIL retry_popped: got count=%0d drained=%0b expected 0/1", count_o, drained_o); end
    endtask

    task automatic test_conflict();
        stallStCommit_i = 1'b1; wrHit_i = 1'b1;
        offer(1'b1, 64'h3010, 2'd0, 64'h9);
        tick();
        offer(1'b0, 64'd0, 2'd0, 64'd0);
        ldCheckValid_i = 1'b1; ldCheckAddr_i = 64'h3017; #1;
        checks++; if (ldConflict_o !== 1'b1) begin errors++; $display("FAIL conf_3017: got %0b expected 1", ldConflict_o); end
        ldCheckAddr_i = 64'h3018; #1;
        checks++; if (ldConflict_o !== 1'b0) begin errors++; $display("FAIL conf_3018: got %0b expected 0", ldConflict_o); end
        ldCheckAddr_i = 64'h300F; #1;
        checks++; if (ldConflict_o !== 1'b0) begin errors++; $display("FAIL conf_300f: got %0b expected 0", ldConflict_o); end
        ldCheckValid_i = 1'b0; ldCheckAddr_i = 64'h3017; #1;
        checks++; if (ldConflict_o !== 1'b0) begin errors++; $display("FAIL conf_novalid: got %0b expected 0", ldConflict_o); end
        stallStCommit_i = 1'b0;
        tick();
        ldCheckValid_i = 1'b1; #1;
        checks++; if (ldConflict_o !== 1'b0) begin errors++; $display("FAIL conf_after_pop: got %0b expected 0", ldConflict_o); end
        ldCheckValid_i = 1'b0;
    endtask

    task automatic test_drain();
        stallStCommit_i = 1'b1; wrHit_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            offer(1'b1, 64'h7000 + 64'(8 * k), 2'd3, 64'(k));
            tick();
        end
        offer(1'b1, 64'h7FF8, 2'd3, 64'hBAD);
        drainReq_i = 1'b1; stallStCommit_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (stCommitReady_o !== 1'b0) begin errors++; $display("FAIL drain_ready[%0d]: got %0b expected 0", k, stCommitReady_o); end
            checks++; if (wrEn_o !== 1'b1 || wrAddr_o !== 64'h7000 + 64'(8 * k)) begin errors++; $display("FAIL drain_pop[%0d]: got en=%0b addr=%0h expected en=1 addr=%0h", k, wrEn_o, wrAddr_o, 64'h7000 + 64'(8 * k)); end
            tick();
        end
        #1;
        checks++; if (drained_o !== 1'b1 || count_o !== 4'd0) begin errors++; $display("FAIL drain_done: got drained=%0b count=%0d expected 1/0", drained_o, count_o); end
        checks++; if (stCommitReady_o !== 1'b0) begin errors++; $display("FAIL drain_ready_held: got %0b expected 0", stCommitReady_o); end
        offer(1'b0, 64'd0, 2'd0, 64'd0);
        drainReq_i = 1'b0; #1;
        checks++; if (stCommitReady_o !== 1'b1) begin errors++; $display("FAIL drain_release: got %0b expected 1", stCommitReady_o); end
    endtask

    task automatic test_reset_mid();
        stallStCommit_i = 1'b1; wrHit_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 64'h8000 + 64'(8 * k), 2'd3, 64'(k));
            tick();
        end
        offer(1'b0, 64'd0, 2'd0, 64'd0);
        stallStCommit_i = 1'b0; drainReq_i = 1'b1;
        #1;
        checks++; if (wrEn_o !== 1'b1 || count_o !== 4'd4) begin errors++; $display("FAIL rmid_pre: got en=%0b count=%0d expected 1/4", wrEn_o, count_o); end
        tick();
        reset = 1'b0; drainReq_i = 1'b0;
        #1;
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count_o); end
        checks++; if (wrEn_o !== 1'b0) begin errors++; $display("FAIL rmid_wren: got %0b expected 0", wrEn_o); end
        checks++; if (drained_o !== 1'b1) begin errors++; $display("FAIL rmid_drained: got %0b expected 1", drained_o); end
        checks++; if (stCommitReady_o !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b expected 1", stCommitReady_o); end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (wrEn_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL rmid_quiet[%0d]: got en=%0b count=%0d expected 0/0", c, wrEn_o, count_o); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_retry();
        test_conflict();
        test_drain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- FIFO of committed stores that sits directly upstream of the L1 data cache write port.
- Accepts stores at retirement and drains them in program order, one per cycle, into the cache port (wrEn/wrAddr/wrData/stSize).
- Retries a drain that misses, honours the cache's stStall back-pressure, and reports load/store address overlap so the LSU can replay a conflicting load.
- Committed stores are architectural: pipeline recovery never discards them.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2.
RETRY_DELAY, 4, cycles to wait after a write miss before reissuing the head store; at least 1.
ADDR_W, 64, store/load virtual address width (SIZE_VIRT_ADDR).
DATA_W, 64, store data width (SIZE_DATA).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stCommitValid_i  in  1  committed store offered
stCommitAddr_i  in  ADDR_W  store address
stCommitData_i  in  DATA_W  store data, LSB-aligned
stCommitSize_i  in  2  LDST_BYTE/HALF_WORD/WORD/DOUBLE_WORD
stCommitReady_o  out  1  buffer can accept this cycle
wrEn_o  out  1  drive cache write port
wrAddr_o  out  ADDR_W  head address
wrData_o  out  DATA_W  head data
stSize_o  out  2  head size
wrHit_i  in  1  cache write hit, same cycle as wrEn_o
stallStCommit_i  in  1  cache cannot take a store this cycle
ldCheckAddr_i  in  ADDR_W  in-flight load address
ldCheckValid_i  in  1  load address valid
ldConflict_o  out  1  load overlaps a buffered store doubleword
drainReq_i  in  1  request full drain (before dcFlush / fence)
drained_o  out  1  buffer empty and FSM idle
count_o  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, reset==0):
  - Head and tail pointers = 0, count = 0, FSM = IDLE, retry counter = 0.
  - stCommitReady_o = 1, wrEn_o = 0, ldConflict_o = 0, drained_o = 1.
  - wrAddr_o, wrData_o and stSize_o present entry 0 contents; entry storage is not reset.
- Enqueue:
  - Occurs when stCommitValid_i && stCommitReady_o. Writes entry[tail]; tail advances, wrapping at DEPTH.
  - stCommitReady_o = (count < DEPTH). It depends only on registered count, never on a pop in the same cycle: a full buffer rejects even when popping.
- FSM:
  - IDLE: count==0. Moves to ISSUE the cycle after count becomes nonzero.
  - ISSUE: wrEn_o = !stallStCommit_i. wrAddr_o, wrData_o and stSize_o are combinational from entry[head].
    - wrEn_o && wrHit_i: pop (head++, count--). Stay in ISSUE if count after the update is nonzero, else go to IDLE.
    - wrEn_o && !wrHit_i: go to RETRY, load retry counter with RETRY_DELAY-1. The head is not popped.
    - stallStCommit_i: wrEn_o = 0, stay in ISSUE.
  - RETRY: wrEn_o = 0. The counter decrements each cycle; at 0 go to ISSUE. Enqueue continues normally.
- Simultaneous enqueue and pop: count is unchanged, both pointers advance.
- Pop order is strictly FIFO. There is no bypass from enqueue to wrEn_o: a store enqueued at cycle t issues at t+1 at the earliest.
- Conflict check:
  - ldConflict_o = ldCheckValid_i && any valid entry has addr[ADDR_W-1:3] == ldCheckAddr_i[ADDR_W-1:3].
  - The check is combinational over all valid entries, including the head in RETRY.
- Drain:
  - drained_o = (count==0) && FSM==IDLE.
  - While drainReq_i is high, stCommitReady_o is forced to 0. Draining continues until drained_o.
- Pointer arithmetic is modulo DEPTH. Count is saturated by construction and never exceeds DEPTH.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro: STB_PERF_CNT_EN.
- When defined: three 32-bit wrapping counters, reset to 0, exposed on outputs perfEnq_o, perfRetry_o and perfFullStall_o.
  - perfEnq_o counts accepted enqueues.
  - perfRetry_o counts ISSUE-to-RETRY transitions.
  - perfFullStall_o counts cycles with stCommitValid_i && !stCommitReady_o.
- When undefined: the counters and ports are absent, and all other behaviour is identical.

Test Plan:
- Reset, then enqueue 3 stores (0x1000 DW 0xAA.., 0x1008 BYTE 0x55, 0x2004 WORD 0x12345678) with wrHit_i=1. Required: wrEn_o on cycles 1-3 after the first enqueue, in the same order with matching size/data; drained_o rises after the third pop.
- Fill all 8 entries with stallStCommit_i=1. Required: stCommitReady_o=0 and count_o=8; a 9th offer is not accepted; releasing the stall pops one per cycle and stCommitReady_o returns to 1 the cycle after the first pop.
- Head misses (wrHit_i=0) with RETRY_DELAY=4. Required: wrEn_o low for exactly 4 cycles, then reissue of the same address; a hit then pops the head.
- Buffered store at 0x3010 BYTE. Required: load check at 0x3017 gives ldConflict_o=1; at 0x3018 gives 0; after the store pops, 0x3017 gives 0.
- Assert drainReq_i with 5 entries buffered. Required: stCommitReady_o=0 throughout; drained_o=1 after 5 hits.
- Pull reset low mid-drain with 4 entries buffered. Required: count_o=0, wrEn_o=0, drained_o=1 immediately, with no further writes.
